// File: rtl/exec_stage.sv
// Execute stage of the multi-cycle RV32IM core: ALU/MUL/DIV, address and branch target generation.
// All mem-stage-facing outputs are registered and hold between operations; DIV/REM iterate 32 cycles.
module exec_stage #(
    parameter logic [2:0] EXEC_STATE = 3'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic [4:0]  alu_op,
    input  logic        use_imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic [2:0]  br_funct3,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        reg_write_in,
    input  logic [4:0]  write_reg_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_addr,
    output logic        branch,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] branch_addr,
    output logic [31:0] reg_write_data,
    output logic        exec_done
);
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3, OP_SLTU = 5'd4,
                           OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_OR = 5'd8, OP_AND = 5'd9,
                           OP_PASSB = 5'd10, OP_AUIPC = 5'd11, OP_MUL = 5'd12, OP_MULH = 5'd13,
                           OP_MULHSU = 5'd14, OP_MULHU = 5'd15, OP_DIV = 5'd16, OP_DIVU = 5'd17,
                           OP_REM = 5'd18, OP_REMU = 5'd19;

    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [5:0]  count_q, count_d;
    logic        neg_q_q, neg_q_d, neg_r_q, neg_r_d, rem_sel_q, rem_sel_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d, branch_q, branch_d;
    logic        reg_write_q, reg_write_d, done_q, done_d;
    logic [31:0] mem_wdata_q, mem_wdata_d, mem_addr_q, mem_addr_d, br_addr_q, br_addr_d;
    logic [31:0] rwd_q, rwd_d;
    logic [4:0]  wreg_q, wreg_d;

    logic [31:0] op_b_s, alu_res_s, res_s, sum_rs1_imm_s, dvd_mag_s, dvs_mag_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s;
    logic [32:0] div_shift_s, div_diff_s;
    logic        is_div_op_s, signed_div_s, rem_op_s, div_zero_s, div_ovf_s, br_cond_s, load_s;

    assign op_b_s        = use_imm ? imm : rs2_data;
    assign sum_rs1_imm_s = rs1_data + imm;
    assign is_div_op_s   = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
    assign signed_div_s  = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign rem_op_s      = (alu_op == OP_REM) || (alu_op == OP_REMU);
    assign div_zero_s    = (op_b_s == 32'd0);
    assign div_ovf_s     = signed_div_s && (rs1_data == 32'h8000_0000) && (op_b_s == 32'hFFFF_FFFF);
    assign dvd_mag_s     = (signed_div_s && rs1_data[31]) ? (32'd0 - rs1_data) : rs1_data;
    assign dvs_mag_s     = (signed_div_s && op_b_s[31]) ? (32'd0 - op_b_s) : op_b_s;
    // One 64x64 multiplier; operand extension selects the ss/su/uu high-half variants.
    assign mul_a_s       = ((alu_op == OP_MULH) || (alu_op == OP_MULHSU)) ?
                           {{32{rs1_data[31]}}, rs1_data} : {32'd0, rs1_data};
    assign mul_b_s       = (alu_op == OP_MULH) ? {{32{op_b_s[31]}}, op_b_s} : {32'd0, op_b_s};
    assign prod_s        = mul_a_s * mul_b_s;
    assign div_shift_s   = {rem_q, quo_q[31]};
    assign div_diff_s    = div_shift_s - {1'b0, dvs_q};

    // Single-cycle ALU result, including the divide-by-zero and signed-overflow shortcuts.
    always_comb begin
        alu_res_s = 32'd0;
        case (alu_op)
            OP_ADD:    alu_res_s = rs1_data + op_b_s;
            OP_SUB:    alu_res_s = rs1_data - op_b_s;
            OP_SLL:    alu_res_s = rs1_data << op_b_s[4:0];
            OP_SLT:    alu_res_s = {31'd0, $signed(rs1_data) < $signed(op_b_s)};
            OP_SLTU:   alu_res_s = {31'd0, rs1_data < op_b_s};
            OP_XOR:    alu_res_s = rs1_data ^ op_b_s;
            OP_SRL:    alu_res_s = rs1_data >> op_b_s[4:0];
            OP_SRA:    alu_res_s = $unsigned($signed(rs1_data) >>> op_b_s[4:0]);
            OP_OR:     alu_res_s = rs1_data | op_b_s;
            OP_AND:    alu_res_s = rs1_data & op_b_s;
            OP_PASSB:  alu_res_s = op_b_s;
            OP_AUIPC:  alu_res_s = pc + imm;
            OP_MUL:    alu_res_s = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_res_s = prod_s[63:32];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (div_zero_s) begin
                    alu_res_s = rem_op_s ? rs1_data : 32'hFFFF_FFFF;
                end else if (div_ovf_s) begin
                    alu_res_s = rem_op_s ? 32'd0 : 32'h8000_0000;
                end else begin
                    alu_res_s = 32'd0;
                end
            end
            default:   alu_res_s = 32'd0;
        endcase
    end

    // Branch condition evaluation.
    always_comb begin
        br_cond_s = 1'b0;
        case (br_funct3)
            3'd0:    br_cond_s = (rs1_data == rs2_data);
            3'd1:    br_cond_s = (rs1_data != rs2_data);
            3'd4:    br_cond_s = ($signed(rs1_data) <  $signed(rs2_data));
            3'd5:    br_cond_s = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6:    br_cond_s = (rs1_data <  rs2_data);
            3'd7:    br_cond_s = (rs1_data >= rs2_data);
            default: br_cond_s = 1'b0;
        endcase
    end

    // Divider result with sign fixup once all 32 quotient bits are in.
    always_comb begin
        if (fsm_q == DIV) begin
            if (rem_sel_q) begin
                res_s = neg_r_q ? (32'd0 - rem_q) : rem_q;
            end else begin
                res_s = neg_q_q ? (32'd0 - quo_q) : quo_q;
            end
        end else begin
            res_s = alu_res_s;
        end
    end

    // FSM next state, divider iteration and output register next values.
    always_comb begin
        fsm_d = fsm_q;   rem_d = rem_q;   quo_d = quo_q;   dvs_d = dvs_q;   count_d = count_q;
        neg_q_d = neg_q_q;  neg_r_d = neg_r_q;  rem_sel_d = rem_sel_q;
        mem_read_d = mem_read_q;  mem_write_d = mem_write_q;  mem_wdata_d = mem_wdata_q;
        mem_addr_d = mem_addr_q;  branch_d = branch_q;  br_addr_d = br_addr_q;
        reg_write_d = reg_write_q;  wreg_d = wreg_q;  rwd_d = rwd_q;
        done_d = 1'b0;
        load_s = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (state == EXEC_STATE) begin
                    if (is_div_op_s && !div_zero_s && !div_ovf_s) begin
                        rem_d     = 32'd0;
                        quo_d     = dvd_mag_s;
                        dvs_d     = dvs_mag_s;
                        count_d   = 6'd0;
                        neg_q_d   = signed_div_s && (rs1_data[31] ^ op_b_s[31]);
                        neg_r_d   = signed_div_s && rs1_data[31];
                        rem_sel_d = rem_op_s;
                        fsm_d     = DIV;
                    end else begin
                        load_s = 1'b1;
                        fsm_d  = DONE;
                    end
                end else begin
                    fsm_d = IDLE;
                end
            end
            DIV: begin
                if (state != EXEC_STATE) begin
                    fsm_d = IDLE;
                end else if (count_q == 6'd32) begin
                    load_s = 1'b1;
                    fsm_d  = DONE;
                end else begin
                    if (!div_diff_s[32]) begin
                        rem_d = div_diff_s[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = div_shift_s[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    count_d = count_q + 6'd1;
                end
            end
            DONE: begin
                if (state != EXEC_STATE) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d = DONE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        if (load_s) begin
            mem_write_d = is_store;
            mem_read_d  = is_load && !is_store;
            mem_wdata_d = is_store ? rs2_data : 32'd0;
            mem_addr_d  = (is_load || is_store) ? sum_rs1_imm_s : res_s;
            reg_write_d = reg_write_in && !is_store;
            wreg_d      = write_reg_in;
            rwd_d       = (is_jal || is_jalr) ? (pc + 32'd4) : res_s;
            branch_d    = is_jal || is_jalr || (is_branch && br_cond_s);
            if (is_jalr) begin
                br_addr_d = sum_rs1_imm_s & ~32'h1;
            end else if (is_jal || is_branch) begin
                br_addr_d = pc + imm;
            end else begin
                br_addr_d = pc + 32'd4;
            end
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;   rem_q <= 32'd0;   quo_q <= 32'd0;   dvs_q <= 32'd0;   count_q <= 6'd0;
            neg_q_q <= 1'b0;  neg_r_q <= 1'b0;  rem_sel_q <= 1'b0;
            mem_read_q <= 1'b0;  mem_write_q <= 1'b0;  mem_wdata_q <= 32'd0;  mem_addr_q <= 32'd0;
            branch_q <= 1'b0;  br_addr_q <= 32'd0;  reg_write_q <= 1'b0;  wreg_q <= 5'd0;
            rwd_q <= 32'd0;  done_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;   rem_q <= rem_d;   quo_q <= quo_d;   dvs_q <= dvs_d;   count_q <= count_d;
            neg_q_q <= neg_q_d;  neg_r_q <= neg_r_d;  rem_sel_q <= rem_sel_d;
            mem_read_q <= mem_read_d;  mem_write_q <= mem_write_d;  mem_wdata_q <= mem_wdata_d;
            mem_addr_q <= mem_addr_d;  branch_q <= branch_d;  br_addr_q <= br_addr_d;
            reg_write_q <= reg_write_d;  wreg_q <= wreg_d;  rwd_q <= rwd_d;  done_q <= done_d;
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_addr       = mem_addr_q;
    assign branch         = branch_q;
    assign reg_write      = reg_write_q;
    assign write_reg      = wreg_q;
    assign branch_addr    = br_addr_q;
    assign reg_write_data = rwd_q;
    assign exec_done      = done_q;
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: hand-computed vectors, one task per scenario.
module tb_exec_stage;
    logic        clk = 1'b1;
    logic        rst;
    logic [2:0]  state;
    logic [4:0]  alu_op;
    logic        use_imm;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, reg_write_in;
    logic [2:0]  br_funct3;
    logic [4:0]  write_reg_in;
    logic        mem_read, mem_write, branch, reg_write, exec_done;
    logic [31:0] mem_write_data, mem_addr, branch_addr, reg_write_data;
    logic [4:0]  write_reg;
    int          checks = 0;
    int          errors = 0;

    exec_stage dut (
        .clk(clk), .rst(rst), .state(state), .alu_op(alu_op), .use_imm(use_imm),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .br_funct3(br_funct3),
        .is_jal(is_jal), .is_jalr(is_jalr), .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_addr(mem_addr), .branch(branch), .reg_write(reg_write), .write_reg(write_reg),
        .branch_addr(branch_addr), .reg_write_data(reg_write_data), .exec_done(exec_done)
    );

    always #5 clk = ~clk;

    task automatic setup(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, input logic ui);
        alu_op = op; rs1_data = a; rs2_data = b; imm = im; pc = p; use_imm = ui;
        is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; br_funct3 = 3'd0;
        is_jal = 1'b0; is_jalr = 1'b0; reg_write_in = 1'b1; write_reg_in = 5'd3;
    endtask

    // Enters EXEC and counts edges (E0 = edge 1) until exec_done is seen; -1 on timeout.
    task automatic run_exec(output int cycles);
        cycles = -1;
        @(negedge clk); state = 3'd2;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (exec_done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic leave_exec();
        @(negedge clk); state = 3'd3;
        @(negedge clk); state = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0; state = 3'd0;
        setup(5'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);
        #50;
        checks++;
        if ({mem_read, mem_write, branch, reg_write, exec_done} !== 5'd0 || mem_addr !== 32'd0 ||
            mem_write_data !== 32'd0 || branch_addr !== 32'd0 || reg_write_data !== 32'd0 ||
            write_reg !== 5'd0) begin
            errors++; $display("FAIL reset_outputs: got rwd=%h addr=%h flags=%b required all zero",
                               reg_write_data, mem_addr, {mem_read, mem_write, branch, reg_write, exec_done});
        end
        #5 rst = 1'b1;
    endtask

    task automatic test_add();
        int c;
        int extra;
        setup(5'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);
        run_exec(c);
        checks++; if (c !== 1) begin errors++; $display("FAIL add_latency: got %0d required 1", c); end
        checks++; if (reg_write_data !== 32'd12) begin errors++; $display("FAIL add_result: got %0d required 12", reg_write_data); end
        checks++; if (branch !== 1'b0 || branch_addr !== 32'd4) begin errors++; $display("FAIL add_branch: got %b/%h required 0/4", branch, branch_addr); end
        checks++; if (reg_write !== 1'b1 || write_reg !== 5'd3 || mem_addr !== 32'd12 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++; $display("FAIL add_ctrl: got rw=%b wr=%0d addr=%0d rd=%b wr=%b required 1 3 12 0 0", reg_write, write_reg, mem_addr, mem_read, mem_write);
        end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (exec_done !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL add_no_reexec: got %0d extra pulses required 0", extra); end
        leave_exec();
    endtask

    task automatic test_store_load();
        int c;
        setup(5'd0, 32'd1000, 32'd1243, 32'd0, 32'd0, 1'b1);
        is_store = 1'b1;
        run_exec(c);
        checks++; if (c !== 1 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'd1000 ||
                      mem_write_data !== 32'd1243 || reg_write !== 1'b0) begin
            errors++; $display("FAIL store: got c=%0d mw=%b mr=%b addr=%0d wd=%0d rw=%b required 1 1 0 1000 1243 0",
                               c, mem_write, mem_read, mem_addr, mem_write_data, reg_write);
        end
        @(negedge clk); state = 3'd3;
        @(posedge clk); #1;
        checks++; if (mem_write !== 1'b1 || mem_addr !== 32'd1000 || mem_write_data !== 32'd1243) begin
            errors++; $display("FAIL store_hold: got mw=%b addr=%0d wd=%0d required 1 1000 1243", mem_write, mem_addr, mem_write_data);
        end
        @(negedge clk); state = 3'd0;
        setup(5'd0, 32'd100, 32'd0, 32'hFFFF_FFFC, 32'd0, 1'b1);
        is_load = 1'b1;
        run_exec(c);
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'd96 || reg_write !== 1'b1) begin
            errors++; $display("FAIL load: got mr=%b mw=%b addr=%0d rw=%b required 1 0 96 1", mem_read, mem_write, mem_addr, reg_write);
        end
        leave_exec();
    endtask

    task automatic test_branch();
        int c;
        setup(5'd1, 32'd9, 32'd9, 32'hFFFF_FFF8, 32'd100, 1'b0);
        is_branch = 1'b1; br_funct3 = 3'd0;
        run_exec(c);
        checks++; if (branch !== 1'b1 || branch_addr !== 32'd92) begin errors++; $display("FAIL beq: got %b/%0d required 1/92", branch, branch_addr); end
        leave_exec();
        setup(5'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'd100, 1'b0);
        is_branch = 1'b1; br_funct3 = 3'd6;
        run_exec(c);
        checks++; if (branch !== 1'b0) begin errors++; $display("FAIL bltu: got %b required 0", branch); end
        leave_exec();
        is_branch = 1'b1; br_funct3 = 3'd4;
        run_exec(c);
        checks++; if (branch !== 1'b1) begin errors++; $display("FAIL blt: got %b required 1", branch); end
        leave_exec();
    endtask

    task automatic test_mul_shift();
        int c;
        logic [4:0]  ops [5] = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd7};
        logic [31:0] av  [5] = '{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bv  [5] = '{32'd6, 32'd3, 32'd2, 32'hFFFF_FFFF, 32'd4};
        logic [31:0] ev  [5] = '{32'd42, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hF800_0000};
        for (int i = 0; i < 5; i++) begin
            setup(ops[i], av[i], bv[i], 32'd0, 32'd0, 1'b0);
            run_exec(c);
            checks++;
            if (c !== 1 || reg_write_data !== ev[i]) begin
                errors++; $display("FAIL mul_shift_%0d: got c=%0d res=%h required 1 %h", i, c, reg_write_data, ev[i]);
            end
            leave_exec();
        end
    endtask

    task automatic test_div();
        int c;
        logic [4:0]  ops [6] = '{5'd16, 5'd18, 5'd17, 5'd16, 5'd18, 5'd16};
        logic [31:0] av  [6] = '{32'hFFFF_FF85, 32'hFFFF_FF85, 32'd100, 32'd77, 32'd77, 32'h8000_0000};
        logic [31:0] bv  [6] = '{32'd10, 32'd10, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ev  [6] = '{32'hFFFF_FFF4, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'd77, 32'h8000_0000};
        int          lat [6] = '{34, 34, 34, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            setup(ops[i], av[i], bv[i], 32'd0, 32'd0, 1'b0);
            run_exec(c);
            checks++;
            if (c !== lat[i] || reg_write_data !== ev[i]) begin
                errors++; $display("FAIL div_%0d: got c=%0d res=%h required %0d %h", i, c, reg_write_data, lat[i], ev[i]);
            end
            leave_exec();
        end
    endtask

    task automatic test_jalr();
        int c;
        setup(5'd0, 32'd1001, 32'd0, 32'd4, 32'd200, 1'b1);
        is_jalr = 1'b1;
        run_exec(c);
        checks++; if (branch !== 1'b1 || branch_addr !== 32'd1004 || reg_write_data !== 32'd204) begin
            errors++; $display("FAIL jalr: got %b/%0d/%0d required 1/1004/204", branch, branch_addr, reg_write_data);
        end
        leave_exec();
    endtask

    task automatic test_abort();
        int pulses;
        setup(5'd16, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
        @(negedge clk); state = 3'd2;
        repeat (5) @(posedge clk);
        @(negedge clk); state = 3'd0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (exec_done !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0 || reg_write_data !== 32'd204 || branch !== 1'b1) begin
            errors++; $display("FAIL div_abort: got pulses=%0d rwd=%0d br=%b required 0 204 1", pulses, reg_write_data, branch);
        end
    endtask

    task automatic test_reset_mid_div();
        int c;
        setup(5'd16, 32'd50, 32'd5, 32'd0, 32'd0, 1'b0);
        @(negedge clk); state = 3'd2;
        repeat (11) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, branch, reg_write, exec_done} !== 5'd0 || reg_write_data !== 32'd0 ||
            branch_addr !== 32'd0 || mem_addr !== 32'd0) begin
            errors++; $display("FAIL reset_mid_div: got rwd=%h br=%b baddr=%h required zero", reg_write_data, branch, branch_addr);
        end
        @(negedge clk); state = 3'd0; rst = 1'b1;
        setup(5'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
        run_exec(c);
        checks++; if (c !== 1 || reg_write_data !== 32'd2) begin
            errors++; $display("FAIL post_reset_add: got c=%0d res=%0d required 1 2", c, reg_write_data);
        end
        leave_exec();
    endtask

    initial begin
        test_reset();
        test_add();
        test_store_load();
        test_branch();
        test_mul_shift();
        test_div();
        test_jalr();
        test_abort();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
